// File: rtl/alu_decode_stage_pkg.sv
// Shared encodings for the ALU decode stage: ALU operation codes, RV32I
// opcodes and the registered command payload.
package alu_decode_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [3:0]  alu_select;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } alu_cmd_t;

  // funct3 -> ALU code; alt selects SUB/SRA variants.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_cmd_decoder.sv
// Combinational RV32I -> ALU command encoder. Illegal encodings collapse to
// a harmless ADD 0,0 with no register write.
module alu_cmd_decoder
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_cmd_t    cmd
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i, imm_s, imm_u;
  logic        is_shift;

  assign opc      = instr[6:0];
  assign rd_f     = instr[11:7];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Decode opcode/funct fields into operands, ALU code and write enable.
  always_comb begin
    cmd = '0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
          cmd.alu_select = alu_from_f3(f3, f7[5]);
          cmd.in_a       = rs1_data;
          cmd.in_b       = rs2_data;
          cmd.rd         = rd_f;
          cmd.rd_we      = 1'b1;
        end else begin
          cmd.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Only shifts carry a funct7; SRAI is the sole alternate form.
        if (!is_shift || f7 == F7_BASE || (f7 == F7_ALT && f3 == 3'b101)) begin
          cmd.alu_select = alu_from_f3(f3, is_shift && f7[5]);
          cmd.in_a       = rs1_data;
          cmd.in_b       = is_shift ? {27'b0, instr[24:20]} : imm_i;
          cmd.rd         = rd_f;
          cmd.rd_we      = 1'b1;
        end else begin
          cmd.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        cmd.in_b  = imm_u;
        cmd.rd    = rd_f;
        cmd.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        cmd.in_a  = pc;
        cmd.in_b  = imm_u;
        cmd.rd    = rd_f;
        cmd.rd_we = 1'b1;
      end
      OPC_LOAD: begin
        cmd.in_a  = rs1_data;
        cmd.in_b  = imm_i;
        cmd.rd    = rd_f;
        cmd.rd_we = 1'b1;
      end
      OPC_STORE: begin
        // Address generation only; rd field holds immediate bits here.
        cmd.in_a = rs1_data;
        cmd.in_b = imm_s;
      end
      default: cmd.illegal = 1'b1;
    endcase
    // x0 is never written.
    if (cmd.rd == 5'd0) cmd.rd_we = 1'b0;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage top: one-entry valid/ready pipeline register in front of the
// ALU, holding the command from alu_cmd_decoder.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_select,
  output logic [31:0] in_a,
  output logic [31:0] in_b,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);

  alu_cmd_t dec_cmd, cmd_q;
  logic     vld_q;
  logic     accept;

  alu_cmd_decoder u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .cmd      (dec_cmd)
  );

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Valid bit: flush beats accept beats consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           vld_q <= 1'b0;
    else if (flush)       vld_q <= 1'b0;
    else if (accept)      vld_q <= 1'b1;
    else if (out_ready)   vld_q <= 1'b0;
  end

  // Payload loads only on a non-flushed accept, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cmd_q <= '0;
    else if (accept && !flush)  cmd_q <= dec_cmd;
  end

  assign out_valid  = vld_q;
  assign alu_select = cmd_q.alu_select;
  assign in_a       = cmd_q.in_a;
  assign in_b       = cmd_q.in_b;
  assign rd         = cmd_q.rd;
  assign rd_we      = cmd_q.rd_we;
  assign illegal    = cmd_q.illegal;

endmodule
